// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Produces {remainder, quotient} for the HI/LO write and a busy stall request.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_DIVZERO,
    S_END
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  // Operand magnitudes; the most negative value maps onto itself and is
  // then treated as an unsigned magnitude.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

  // One shift-subtract step; quot_q doubles as the dividend shift register,
  // its MSB feeding the partial remainder while quotient bits enter at the LSB.
  logic [WIDTH:0]   rem_sh, rem_sub, it_rem;
  logic [WIDTH-1:0] it_quot, q_fin, r_fin;
  logic             rem_ge;

  // Iteration datapath and sign fix-up of the final iteration's values.
  always_comb begin
    rem_sh  = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    rem_ge  = rem_q[WIDTH] | (rem_sh >= {1'b0, dvs_q});
    it_rem  = rem_ge ? rem_sub : rem_sh;
    it_quot = {quot_q[WIDTH-2:0], rem_ge};
    q_fin   = qneg_q ? -it_quot : it_quot;
    r_fin   = rneg_q ? -it_rem[WIDTH-1:0] : it_rem[WIDTH-1:0];
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          cnt_d = '0;
          rem_d = '0;
          if (divisor == '0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d = S_ON;
            quot_d  = a_mag;
            dvs_d   = b_mag;
            qneg_d  = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d  = signed_div & dividend[WIDTH-1];
          end
        end
      end
      S_ON: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = it_rem;
          quot_d = it_quot;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d  = S_END;
            result_d = {r_fin, q_fin};
          end
        end
      end
      S_DIVZERO: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_END;
          result_d = '0;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // ready is suppressed by an annul arriving in the END cycle.
  assign ready  = (state_q == S_END) && !annul;
  assign busy   = (state_q != S_IDLE);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .dividend   (dividend),
    .divisor    (divisor),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division truncating toward zero; x/0 gives 0.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
    return (b == 32'd0) ? 2 : 33;
  endfunction

  function automatic logic [63:0] busy_mask(input int lat);
    logic [63:0] m = '0;
    for (int c = 1; c <= lat; c++) m[c] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide in the current cycle (cycle 0) and observes up to 40
  // cycles; returns in the cycle after the first ready pulse.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                        output logic [63:0] res, output int rcyc, output int rcnt,
                        output logic [63:0] bvec);
    rcyc = -1;
    rcnt = 0;
    bvec = '0;
    res  = '0;
    start = 1'b1; signed_div = s; dividend = a; divisor = b;
    #1;
    bvec[0] = busy;
    if (ready === 1'b1) rcnt++;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_div = 1'($urandom);
      end
      #1;
      bvec[c] = busy;
      if (ready === 1'b1) begin
        rcnt++;
        if (rcyc < 0) begin
          rcyc = c;
          res  = result;
        end
      end
      if (rcyc >= 0 && c == rcyc + 1) break;
    end
    if (rcyc < 0) res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    checks++;
    if (result !== 64'd0 || ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got result=%h ready=%b busy=%b want 0/0/0", result, ready, busy);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ready=%b busy=%b want 0/0", ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd5, 32'h80000000};
    logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1};
    bit          ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] res, bvec, want;
    int rcyc, rcnt;
    for (int i = 0; i < 7; i++) begin
      do_div(ta[i], tb[i], ts[i], res, rcyc, rcnt, bvec);
      want = model(ta[i], tb[i], ts[i]);
      checks++;
      if (res !== want) begin
        errors++;
        $display("FAIL directed_result[%0d] got %h want %h", i, res, want);
      end
      checks++;
      if (rcyc != exp_latency(tb[i]) || rcnt != 1) begin
        errors++;
        $display("FAIL directed_ready[%0d] got cycle %0d pulses %0d want cycle %0d pulses 1",
                 i, rcyc, rcnt, exp_latency(tb[i]));
      end
      checks++;
      if (bvec !== busy_mask(exp_latency(tb[i]))) begin
        errors++;
        $display("FAIL directed_busy[%0d] got %h want %h", i, bvec, busy_mask(exp_latency(tb[i])));
      end
    end
  endtask

  // Consecutive divides, each issued in the IDLE cycle right after END.
  task automatic test_back_to_back();
    logic [63:0] res, bvec, want;
    logic [31:0] a, b;
    bit s;
    int rcyc, rcnt, sel;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom & 32'h000000FF;
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      do_div(a, b, s, res, rcyc, rcnt, bvec);
      want = model(a, b, s);
      checks++;
      if (res !== want || rcyc != exp_latency(b) || rcnt != 1) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h s=%0d got %h @%0d x%0d want %h @%0d x1",
                 i, a, b, s, res, rcyc, rcnt, want, exp_latency(b));
      end
    end
  endtask

  task automatic test_annul();
    logic [63:0] res, bvec, prior;
    int rcyc, rcnt, bad;
    do_div(32'd12345, 32'd11, 1'b0, res, rcyc, rcnt, bvec);
    prior = model(32'd12345, 32'd11, 1'b0);
    checks++;
    if (res !== prior) begin
      errors++;
      $display("FAIL annul_prior got %h want %h", res, prior);
    end
    // Annul in cycle 10 of DIVU 100/7.
    bad = 0;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd100; divisor = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      annul = (c == 10);
      #1;
      if (ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    tick();
    annul = 1'b0;
    #1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL annul_inflight got %0d bad cycles want 0", bad);
    end
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== prior) begin
      errors++;
      $display("FAIL annul_abort got busy=%b ready=%b result=%h want 0/0/%h", busy, ready, result, prior);
    end
    do_div(32'd100, 32'd7, 1'b0, res, rcyc, rcnt, bvec);
    checks++;
    if (res !== {32'd2, 32'd14} || rcyc != 33 || bvec !== busy_mask(33)) begin
      errors++;
      $display("FAIL annul_restart got %h @%0d busy=%h want %h @33", res, rcyc, bvec, {32'd2, 32'd14});
    end
    // Start together with annul in IDLE is ignored.
    bad = 0;
    start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0; annul = 1'b0;
      #1;
      if (busy !== 1'b0 || ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || result !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL annul_with_start got %0d bad cycles result=%h want 0 and %h", bad, result, {32'd2, 32'd14});
    end
    // Annul in DIVZERO.
    start = 1'b1; dividend = 32'd5; divisor = 32'd0;
    tick();
    start = 1'b0; annul = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL annul_divzero_c1 got busy=%b ready=%b want 1/0", busy, ready);
    end
    tick();
    annul = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL annul_divzero got busy=%b ready=%b result=%h want 0/0/%h", busy, ready, result, {32'd2, 32'd14});
    end
  endtask

  task automatic test_ignore_start();
    logic [63:0] res, want;
    int rcyc, rcnt, bad;
    rcyc = -1; rcnt = 0; res = '0;
    start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = (c == 5 || c == 20);
      signed_div = 1'($urandom);
      dividend = $urandom;
      divisor = $urandom_range(0, 3);
      #1;
      if (ready === 1'b1) begin
        rcnt++;
        if (rcyc < 0) begin rcyc = c; res = result; end
      end
      if (rcyc >= 0 && c == rcyc + 1) break;
    end
    start = 1'b0;
    want = model(32'd1000, 32'd3, 1'b0);
    checks++;
    if (res !== want || rcyc != 33 || rcnt != 1) begin
      errors++;
      $display("FAIL ignore_start got %h @%0d x%0d want %h @33 x1", res, rcyc, rcnt, want);
    end
    // rst in cycle 15 of a divide.
    start = 1'b1; dividend = 32'd1000; divisor = 32'd7;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 1'b0;
      rst = (c == 15);
      #1;
    end
    checks++;
    if (result !== 64'd0 || ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got result=%h ready=%b busy=%b want 0/0/0", result, ready, busy);
    end
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #1;
      if (ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_annul();
    test_ignore_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
